seq_rippleadd: RTL

SEQ_RIPPLEADD -- requirements
Module: seq_rippleadd

---
 rtl/rippleadd_pkg.sv | 10 +
 rtl/seq_rippleadd_chunk_add.sv | 23 ++
 rtl/seq_rippleadd.sv | 109 ++++++++++
 3 files changed

// File: rtl/rippleadd_pkg.sv
// Shared definitions for the chunked sequential ripple adder: FSM state encoding.
package rippleadd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/seq_rippleadd_chunk_add.sv
// Combinational CHUNK-bit ripple-carry adder built from a chain of full adders.
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[CHUNK];

endmodule

// File: rtl/seq_rippleadd.sv
// Sequential adder: CHUNK bits per cycle, carry held in a register between chunks.
// Optional subtract (a + ~b + 1) is compiled in when RIPPLE_SUB_EN is defined.
module seq_rippleadd
  import rippleadd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef RIPPLE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy,
  output state_t           dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE.

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_sum;

  logic             w_sub;
  logic [CHUNK-1:0] w_sum_chunk;
  logic             w_cout;
  logic [WIDTH-1:0] w_sum_next;

`ifdef RIPPLE_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
    .i_a    (r_a[CHUNK-1:0]),
    .i_b    (r_b[CHUNK-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum_chunk),
    .o_cout (w_cout)
  );

  // Operands shift right and result chunks shift in from the top, so the
  // low chunk of each operand register is always the one being added.
  assign w_sum_next = (r_sum[WIDTH-1:0] >> CHUNK) | (WIDTH'(w_sum_chunk) << (WIDTH - CHUNK));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_sub ? ~b : b;
            r_carry <= w_sub;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a              <= r_a >> CHUNK;
          r_b              <= r_b >> CHUNK;
          r_carry          <= w_cout;
          r_sum[WIDTH-1:0] <= w_sum_next;
          if (r_cnt == LAST_CNT) begin
            r_sum[WIDTH] <= w_cout;
            r_cnt        <= '0;
            r_state      <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign sum       = r_sum;
  assign dbg_state = r_state;

endmodule
